// File: rtl/wave_meas_if.sv
// rtl/wave_meas_if.sv - sample inputs, measurement request and result bundle for wave_meas
interface wave_meas_if;
    logic [13:0] ad_a;
    logic [13:0] ad_b;
    logic        start;
    logic        busy;
    logic        valid;
    logic        timeout;
    logic        b_miss;
    logic [19:0] period;
    logic [13:0] peak_a;
    logic [13:0] trough_a;
    logic [13:0] amp_a;
    logic [19:0] phase_lag;

    modport master (
        output ad_a, ad_b, start,
        input  busy, valid, timeout, b_miss, period, peak_a, trough_a, amp_a, phase_lag
    );

    modport slave (
        input  ad_a, ad_b, start,
        output busy, valid, timeout, b_miss, period, peak_a, trough_a, amp_a, phase_lag
    );
endinterface

// File: rtl/wave_meas.sv
// rtl/wave_meas.sv - one-period measurement of channel A (period, peak, trough, amplitude) and B lag
module wave_meas #(
    parameter int unsigned HYST = 64,
    parameter logic [19:0] TMAX = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    wave_meas_if.slave wm
);
    localparam logic [13:0] TH_HI   = 14'(8192 + HYST);
    localparam logic [13:0] TH_LO   = 14'(8192 - HYST);
    // tcnt reads k-1 in the k-th cycle after acceptance, so the pulse lands TMAX cycles after start
    localparam logic [19:0] TO_LAST = TMAX - 20'd2;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

    state_t      state;
    state_t      state_nx;

    logic [13:0] s_a;
    logic [13:0] s_b;
    logic        arm_a;
    logic        arm_b;
    logic        cross_a;
    logic        cross_b;
    logic        start_acc;
    logic        to_hit;

    logic [19:0] tcnt;
    logic [19:0] pcnt;
    logic [13:0] pk;
    logic [13:0] tr;
    logic [19:0] lag;
    logic        b_seen;

    logic [19:0] period_q;
    logic [13:0] peak_q;
    logic [13:0] trough_q;
    logic [13:0] amp_q;
    logic [19:0] lag_q;
    logic        miss_q;
    logic        timeout_q;

    assign cross_a   = arm_a && (s_a >= TH_HI);
    assign cross_b   = arm_b && (s_b >= TH_HI);
    assign start_acc = (state == IDLE) && wm.start;
    assign to_hit    = (tcnt == TO_LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (wm.start) state_nx = ARM;
            // timeout beats a late sync crossing; a closing crossing beats timeout
            ARM: begin
                if (to_hit)       state_nx = IDLE;
                else if (cross_a) state_nx = MEAS;
            end
            MEAS: begin
                if (cross_a)     state_nx = DONE;
                else if (to_hit) state_nx = IDLE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s_a   <= '0;
            s_b   <= '0;
            arm_a <= 1'b0;
            arm_b <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            s_a   <= wm.ad_a;
            s_b   <= wm.ad_b;

            if (start_acc) begin
                arm_a <= 1'b0;
                arm_b <= 1'b0;
            end else begin
                if (s_a < TH_LO)  arm_a <= 1'b1;
                else if (cross_a) arm_a <= 1'b0;
                if (s_b < TH_LO)  arm_b <= 1'b1;
                else if (cross_b) arm_b <= 1'b0;
            end

            if (state == IDLE)
                tcnt <= '0;
            else if ((state == ARM) || (state == MEAS))
                tcnt <= tcnt + 20'd1;
        end
    end

    // Trackers: the sync cycle seeds them, MEAS refines them up to the closing cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt   <= '0;
            pk     <= '0;
            tr     <= '0;
            lag    <= '0;
            b_seen <= 1'b0;
        end else if ((state == ARM) && (state_nx == MEAS)) begin
            pcnt   <= '0;
            pk     <= s_a;
            tr     <= s_a;
            lag    <= '0;
            b_seen <= cross_b;
        end else if ((state == MEAS) && !cross_a) begin
            pcnt <= pcnt + 20'd1;
            if (s_a > pk) pk <= s_a;
            if (s_a < tr) tr <= s_a;
            if (cross_b && !b_seen) begin
                b_seen <= 1'b1;
                lag    <= pcnt + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q  <= '0;
            peak_q    <= '0;
            trough_q  <= '0;
            amp_q     <= '0;
            lag_q     <= '0;
            miss_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= ((state == ARM) || (state == MEAS)) && (state_nx == IDLE);
            if ((state == MEAS) && cross_a) begin
                period_q <= pcnt + 20'd1;
                peak_q   <= pk;
                trough_q <= tr;
                amp_q    <= pk - tr;
                lag_q    <= b_seen ? lag : 20'd0;
                miss_q   <= !b_seen;
            end
        end
    end

    assign wm.busy      = (state == ARM) || (state == MEAS);
    assign wm.valid     = (state == DONE);
    assign wm.timeout   = timeout_q;
    assign wm.b_miss    = miss_q;
    assign wm.period    = period_q;
    assign wm.peak_a    = peak_q;
    assign wm.trough_a  = trough_q;
    assign wm.amp_a     = amp_q;
    assign wm.phase_lag = lag_q;
endmodule

// File: tb/tb_wave_meas.sv
// tb/tb_wave_meas.sv - randomized and directed bench for wave_meas against a hysteresis-comparator model
module tb_wave_meas;
    localparam int HYST = 64;
    localparam int TMAX = 1000;
    localparam int HI   = 8192 + HYST;
    localparam int LO   = 8192 - HYST;
    localparam int NH   = 80000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    wave_meas_if wm ();

    wave_meas #(.HYST(HYST), .TMAX(20'(TMAX))) dut (
        .clk (clk),
        .rst (rst),
        .wm  (wm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // waveform configuration, written only at posedge+3 so the driver at posedge+1 never races it
    int kind = 3, per = 100, lo = 0, hi = 16383, bdelay = 0, bval = 0, ph0 = 0;
    bit bmode = 1'b0;
    logic [13:0] ha [0:NH-1];
    logic [13:0] hb [0:NH-1];

    // previously reported results, which must survive a timeout
    int p_per = 0, p_pk = 0, p_tr = 0, p_amp = 0, p_lag = 0, p_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] gen(input int ph);
        int p, h, d, v;
        p = ((ph % per) + per) % per;
        h = per / 2;
        d = per / 20;
        case (kind)
            0: v = (p < h) ? lo : hi;
            1: v = (p < h) ? lo + (hi - lo) * p / h : hi - (hi - lo) * (p - h) / h;
            2: begin
                if (p < h - d)        v = lo;
                else if (p < h)       v = 8152 + int'($urandom_range(0, 80));
                else if (p < per - d) v = hi;
                else                  v = 8152 + int'($urandom_range(0, 80));
            end
            default: v = 8192;
        endcase
        return 14'(v);
    endfunction

    initial begin
        wm.ad_a  = '0;
        wm.ad_b  = '0;
        wm.start = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wm.ad_a = gen(cyc - ph0);
            wm.ad_b = bmode ? 14'(bval) : gen(cyc - ph0 - bdelay);
            if (cyc < NH) begin
                ha[cyc] = wm.ad_a;
                hb[cyc] = wm.ad_b;
            end
        end
    end

    // Reference: each channel is a Schmitt comparator whose output is the side of the band last
    // left; a rising edge is a low->high change. Start forgets history and assumes "not low".
    task automatic model(input int t, output bit e_to, output int e_ev, output int e_per,
                         output int e_pk, output int e_tr, output int e_lag, output int e_miss);
        int ra[$];
        int rb[$];
        bit lvl_a, lvl_b;
        int m0, m1;
        lvl_a = 1'b1;
        lvl_b = 1'b1;
        for (int m = t; m <= t + TMAX - 2 && m < NH; m++) begin
            if (int'(hb[m]) < LO) lvl_b = 1'b0;
            else if (int'(hb[m]) >= HI) begin
                if (!lvl_b) rb.push_back(m);
                lvl_b = 1'b1;
            end
            if (int'(ha[m]) < LO) lvl_a = 1'b0;
            else if (int'(ha[m]) >= HI) begin
                if (!lvl_a) ra.push_back(m);
                lvl_a = 1'b1;
            end
            if (ra.size() == 2) break;
        end
        e_to = 1'b0; e_per = 0; e_pk = 0; e_tr = 0; e_lag = 0; e_miss = 0;
        if (ra.size() < 2) begin
            e_to = 1'b1;
            e_ev = t + TMAX;
            return;
        end
        m0 = ra[0];
        m1 = ra[1];
        e_ev  = m1 + 2;
        e_per = m1 - m0;
        e_pk  = 0;
        e_tr  = 16383;
        for (int m = m0; m < m1; m++) begin
            if (int'(ha[m]) > e_pk) e_pk = int'(ha[m]);
            if (int'(ha[m]) < e_tr) e_tr = int'(ha[m]);
        end
        e_miss = 1;
        foreach (rb[i]) begin
            if (rb[i] >= m0 && rb[i] < m1) begin
                e_lag  = rb[i] - m0;
                e_miss = 0;
                break;
            end
        end
    endtask

    task automatic config_wave(input int k, input int p, input int l, input int h,
                               input bit bm, input int bd, input int bv, input int off);
        @(posedge clk);
        #3;
        kind = k; per = p; lo = l; hi = h; bmode = bm; bdelay = bd; bval = bv;
        ph0 = cyc + 1 - off;
    endtask

    task automatic measure(input string tag, input bit poke);
        int t, ev, e_ev, e_per, e_pk, e_tr, e_lag, e_miss, extra;
        bit gv, gt, gb, e_to;
        @(posedge clk);
        #3;
        t = cyc;
        wm.start = 1'b1;
        @(posedge clk);
        #3;
        wm.start = 1'b0;
        @(negedge clk);
        chk({tag, ":busy_after_start"}, 32'(wm.busy), 32'd1);
        ev = -1; gv = 1'b0; gt = 1'b0; gb = 1'b1;
        for (int k = 0; k < TMAX + 20; k++) begin
            if (wm.valid || wm.timeout) begin
                ev = cyc; gv = wm.valid; gt = wm.timeout; gb = wm.busy;
                break;
            end
            wm.start = poke && (k == 8 || k == 80);
            @(negedge clk);
        end
        wm.start = 1'b0;
        if (ev < 0) begin
            chk({tag, ":end_event_seen"}, 32'd0, 32'd1);
            return;
        end
        model(t, e_to, e_ev, e_per, e_pk, e_tr, e_lag, e_miss);
        chk({tag, ":end_latency"}, 32'(ev - t), 32'(e_ev - t));
        chk({tag, ":valid"}, 32'(gv), 32'(!e_to));
        chk({tag, ":timeout"}, 32'(gt), 32'(e_to));
        chk({tag, ":busy_at_end"}, 32'(gb), 32'd0);
        if (!e_to) begin
            p_per = e_per; p_pk = e_pk; p_tr = e_tr; p_amp = e_pk - e_tr;
            p_lag = e_lag; p_miss = e_miss;
        end
        chk({tag, ":period"}, 32'(wm.period), 32'(p_per));
        chk({tag, ":peak_a"}, 32'(wm.peak_a), 32'(p_pk));
        chk({tag, ":trough_a"}, 32'(wm.trough_a), 32'(p_tr));
        chk({tag, ":amp_a"}, 32'(wm.amp_a), 32'(p_amp));
        chk({tag, ":phase_lag"}, 32'(wm.phase_lag), 32'(p_lag));
        chk({tag, ":b_miss"}, 32'(wm.b_miss), 32'(p_miss));
        @(negedge clk);
        chk({tag, ":one_cycle_pulse"}, 32'(wm.valid | wm.timeout), 32'd0);
        if (poke) begin
            extra = 0;
            for (int k = 0; k < 150; k++) begin
                @(negedge clk);
                if (wm.valid || wm.busy) extra++;
            end
            chk({tag, ":no_queued_start"}, 32'(extra), 32'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":busy"}, 32'(wm.busy), 32'd0);
        chk({tag, ":valid"}, 32'(wm.valid), 32'd0);
        chk({tag, ":timeout"}, 32'(wm.timeout), 32'd0);
        chk({tag, ":b_miss"}, 32'(wm.b_miss), 32'd0);
        chk({tag, ":results"}, 32'(wm.period) | 32'(wm.peak_a) | 32'(wm.trough_a)
                               | 32'(wm.amp_a) | 32'(wm.phase_lag), 32'd0);
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, p, l, h, bm, bv, bd;
        repeat (4) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        config_wave(0, 100, 0, 16383, 1'b0, 0, 0, 0);
        measure("square", 1'b0);
        chk("square:period_100", 32'(wm.period), 32'd100);
        chk("square:amp_16383", 32'(wm.amp_a), 32'd16383);
        chk("square:lag_0", 32'(wm.phase_lag), 32'd0);

        config_wave(0, 100, 0, 16383, 1'b0, 25, 0, 0);
        measure("delay25", 1'b0);
        chk("delay25:lag_25", 32'(wm.phase_lag), 32'd25);

        config_wave(1, 512, 4096, 12288, 1'b1, 0, 0, 0);
        measure("tri", 1'b0);
        chk("tri:period_512", 32'(wm.period), 32'd512);
        chk("tri:peak_12288", 32'(wm.peak_a), 32'd12288);
        chk("tri:trough_4096", 32'(wm.trough_a), 32'd4096);
        chk("tri:b_miss_1", 32'(wm.b_miss), 32'd1);

        config_wave(3, 100, 0, 0, 1'b1, 0, 8192, 0);
        measure("timeout", 1'b0);
        chk("timeout:held_amp_8192", 32'(wm.amp_a), 32'd8192);

        config_wave(2, 200, 0, 16383, 1'b0, 0, 0, 0);
        measure("noisy", 1'b0);
        chk("noisy:period_200", 32'(wm.period), 32'd200);

        config_wave(0, 100, 0, 16383, 1'b0, 10, 0, 0);
        @(posedge clk);
        #3;
        wm.start = 1'b1;
        @(posedge clk);
        #3;
        wm.start = 1'b0;
        repeat (70) @(negedge clk);
        chk("rst_mid:busy_before", 32'(wm.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        p_per = 0; p_pk = 0; p_tr = 0; p_amp = 0; p_lag = 0; p_miss = 0;
        @(negedge clk);
        rst = 1'b0;
        measure("after_rst", 1'b1);
        chk("after_rst:period_100", 32'(wm.period), 32'd100);

        for (int i = 0; i < 20; i++) begin
            k  = int'($urandom_range(0, 2));
            p  = 20 * int'($urandom_range(2, 12));
            l  = int'($urandom_range(0, 4000));
            h  = int'($urandom_range(12400, 16383));
            bm = int'($urandom_range(0, 3) == 0);
            bd = int'($urandom_range(0, p - 1));
            case ($urandom_range(0, 2))
                0:       bv = 0;
                1:       bv = 8192;
                default: bv = 16383;
            endcase
            config_wave(k, p, l, h, bm[0], bd, bv, int'($urandom_range(0, p - 1)));
            measure($sformatf("rand%0d", i), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
